// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - run/halt/single-step two-phase clock sequencer
module phase_sequencer #(
    parameter int TW      = 4,
    parameter int PH1_LEN = 2,
    parameter int PH2_LEN = 2,
    parameter int GAP_LEN = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_req_i,
    output logic             ph1_o,
    output logic             ph2_o,
    output logic             sync_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cyc_cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_P1, S_G1, S_P2, S_G2} state_t;

    localparam logic [TW-1:0] P1_LAST  = TW'(PH1_LEN - 1);
    localparam logic [TW-1:0] P2_LAST  = TW'(PH2_LEN - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam bit            NO_GAP   = (GAP_LEN == 0);

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ph1_q, ph1_d;
    logic               ph2_q, ph2_d;
    logic               sync_q, sync_d;
    logic               halted_q, halted_d;
    logic               cycle_end;
    logic               start_cycle;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            step_q   <= 1'b0;
            cnt_q    <= '0;
            ph1_q    <= 1'b0;
            ph2_q    <= 1'b0;
            sync_q   <= 1'b0;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            ph1_q    <= ph1_d;
            ph2_q    <= ph2_d;
            sync_q   <= sync_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        step_d      = step_q;
        cnt_d       = cnt_q;
        cycle_end   = 1'b0;
        start_cycle = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                // STEP overrides HALT_REQ; the latch only matters when RUN is low
                if ((run_i & ~halt_req_i) | step_i) begin
                    state_d     = S_P1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    step_d      = step_i & ~run_i;
                    start_cycle = 1'b1;
                end
            end
            S_P1: begin
                if (timer_q == P1_LAST) begin
                    timer_d = '0;
                    state_d = NO_GAP ? S_P2 : S_G1;
                end
            end
            S_G1: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = S_P2;
                end
            end
            S_P2: begin
                if (timer_q == P2_LAST) begin
                    timer_d = '0;
                    if (NO_GAP) cycle_end = 1'b1;
                    else        state_d   = S_G2;
                end
            end
            S_G2: begin
                if (timer_q == GAP_LAST) cycle_end = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
        if (cycle_end) begin
            timer_d = '0;
            if (run_i & ~halt_req_i & ~step_q) begin
                state_d     = S_P1;
                cnt_d       = cnt_q + CNT_W'(1);
                start_cycle = 1'b1;
            end else begin
                state_d = S_IDLE;
                step_d  = 1'b0;
            end
        end
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        ph1_d    = (state_d == S_P1);
        ph2_d    = (state_d == S_P2);
        sync_d   = start_cycle;
        halted_d = (state_d == S_IDLE);
    end

    assign ph1_o     = ph1_q;
    assign ph2_o     = ph2_q;
    assign sync_o    = sync_q;
    assign halted_o  = halted_q;
    assign cyc_cnt_o = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed self-checking bench for phase_sequencer
module tb_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, run, step, halt_req;
    logic a_ph1, a_ph2, a_sync, a_halted;
    logic [7:0] a_cnt;
    logic b_ph1, b_ph2, b_sync, b_halted;
    logic [7:0] b_cnt;
    logic c_ph1, c_ph2, c_sync, c_halted;
    logic [1:0] c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    phase_sequencer u_dflt (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .step_i(step), .halt_req_i(halt_req),
        .ph1_o(a_ph1), .ph2_o(a_ph2), .sync_o(a_sync), .halted_o(a_halted), .cyc_cnt_o(a_cnt)
    );

    phase_sequencer #(.PH1_LEN(1), .PH2_LEN(3), .GAP_LEN(0)) u_gap0 (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .step_i(step), .halt_req_i(halt_req),
        .ph1_o(b_ph1), .ph2_o(b_ph2), .sync_o(b_sync), .halted_o(b_halted), .cyc_cnt_o(b_cnt)
    );

    phase_sequencer #(.CNT_W(2)) u_wrap (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .step_i(step), .halt_req_i(halt_req),
        .ph1_o(c_ph1), .ph2_o(c_ph2), .sync_o(c_sync), .halted_o(c_halted), .cyc_cnt_o(c_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("no_overlap", 32'(a_ph1 & a_ph2), 0);
        check("sync_implies_ph1", 32'(a_sync & ~a_ph1), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Default timing: PH1 at idx 0,1; PH2 at idx 3,4; gaps at 2,5
    task automatic check_dflt(input string tag, input int idx);
        check({tag, "_ph1"}, 32'(a_ph1), (idx < 2) ? 1 : 0);
        check({tag, "_ph2"}, 32'(a_ph2), (idx == 3 || idx == 4) ? 1 : 0);
        check({tag, "_sync"}, 32'(a_sync), (idx == 0) ? 1 : 0);
        check({tag, "_halted"}, 32'(a_halted), 0);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        #12;
        check("rst_ph1", 32'(a_ph1), 0);
        check("rst_ph2", 32'(a_ph2), 0);
        check("rst_sync", 32'(a_sync), 0);
        check("rst_halted", 32'(a_halted), 1);
        check("rst_cnt", 32'(a_cnt), 0);
        do_reset();

        // Free run: all three instances in parallel
        run = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            check_dflt("run", (k - 1) % 6);
            check("gap0_ph1", 32'(b_ph1), ((k - 1) % 4 == 0) ? 1 : 0);
            check("gap0_ph2", 32'(b_ph2), ((k - 1) % 4 != 0) ? 1 : 0);
            if ((k - 1) % 6 == 0)
                check("wrap_cnt", 32'(c_cnt), (((k - 1) / 6) + 1) % 4);
            if (k == 18) begin
                check("run_cnt18", 32'(a_cnt), 3);
                check("gap0_cnt18", 32'(b_cnt), 5);
            end
            if (k == 30) run = 1'b0;
        end
        tick();
        check("run_stop_halted", 32'(a_halted), 1);
        check("run_stop_ph1", 32'(a_ph1), 0);
        check("run_stop_cnt", 32'(a_cnt), 5);

        // Single step with an ignored second pulse mid-cycle
        do_reset();
        step = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            step = (k == 3) ? 1'b1 : 1'b0;
            check_dflt("step", k - 1);
            check("step_cnt", 32'(a_cnt), 1);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            check("step_idle_halted", 32'(a_halted), 1);
            check("step_idle_ph1", 32'(a_ph1), 0);
            check("step_idle_cnt", 32'(a_cnt), 1);
        end

        // Halt request raised during P1 lets the cycle finish
        do_reset();
        run = 1'b1;
        tick();
        check_dflt("halt", 0);
        halt_req = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            tick();
            check_dflt("halt", k - 1);
        end
        tick();
        check("halt_halted", 32'(a_halted), 1);
        tick();
        check("halt_stay", 32'(a_halted), 1);
        check("halt_cnt", 32'(a_cnt), 1);
        halt_req = 1'b0;
        tick();
        check("resume_sync", 32'(a_sync), 1);
        check("resume_ph1", 32'(a_ph1), 1);
        check("resume_cnt", 32'(a_cnt), 2);

        // Async reset in the middle of PH2
        do_reset();
        run = 1'b1;
        repeat (4) tick();
        check("pre_rst_ph2", 32'(a_ph2), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_ph2", 32'(a_ph2), 0);
        check("midrst_halted", 32'(a_halted), 1);
        check("midrst_cnt", 32'(a_cnt), 0);
        run = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_halted", 32'(a_halted), 1);
            check("post_rst_ph1", 32'(a_ph1), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
